// File: rtl/id_stage_fwd_pkg.sv
// Shared constants and types for the ID stage: ALU op codes, MIPS opcode/funct
// encodings and the MOV-type selector used by the decoder and the top level.
package id_stage_fwd_pkg;

   localparam int AluOpLength = 8;

   typedef enum logic [AluOpLength-1:0] {
      ALU_NOP  = 8'h00,
      ALU_AND  = 8'h01,
      ALU_OR   = 8'h02,
      ALU_XOR  = 8'h03,
      ALU_NOR  = 8'h04,
      ALU_SLL  = 8'h05,
      ALU_SRL  = 8'h06,
      ALU_SRA  = 8'h07,
      ALU_MOVZ = 8'h08,
      ALU_MOVN = 8'h09,
      ALU_MFHI = 8'h0a,
      ALU_MFLO = 8'h0b,
      ALU_MTHI = 8'h0c,
      ALU_MTLO = 8'h0d
   } alu_op_e;

   typedef enum logic [1:0] {
      MOV_NONE = 2'd0,
      MOV_N    = 2'd1,
      MOV_Z    = 2'd2
   } mov_e;

   localparam logic [5:0] EXE_SPECIAL = 6'b000000;
   localparam logic [5:0] EXE_ANDI    = 6'b001100;
   localparam logic [5:0] EXE_ORI     = 6'b001101;
   localparam logic [5:0] EXE_XORI    = 6'b001110;
   localparam logic [5:0] EXE_LUI     = 6'b001111;

   localparam logic [5:0] EXE_SLL  = 6'b000000;
   localparam logic [5:0] EXE_SRL  = 6'b000010;
   localparam logic [5:0] EXE_SRA  = 6'b000011;
   localparam logic [5:0] EXE_SLLV = 6'b000100;
   localparam logic [5:0] EXE_SRLV = 6'b000110;
   localparam logic [5:0] EXE_SRAV = 6'b000111;
   localparam logic [5:0] EXE_MOVZ = 6'b001010;
   localparam logic [5:0] EXE_MOVN = 6'b001011;
   localparam logic [5:0] EXE_MFHI = 6'b010000;
   localparam logic [5:0] EXE_MTHI = 6'b010001;
   localparam logic [5:0] EXE_MFLO = 6'b010010;
   localparam logic [5:0] EXE_MTLO = 6'b010011;
   localparam logic [5:0] EXE_AND  = 6'b100100;
   localparam logic [5:0] EXE_OR   = 6'b100101;
   localparam logic [5:0] EXE_XOR  = 6'b100110;
   localparam logic [5:0] EXE_NOR  = 6'b100111;

   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'd0;

endpackage

// File: rtl/id_stage_fwd_decode.sv
// Purely combinational instruction decoder: ALU op, register-read flags, the
// constant operand for each slot, write-back target, MOV type and invalid flag.
module id_stage_fwd_decode
   import id_stage_fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [31:0]       inst,
   output alu_op_e           aluop,
   output logic              use_rs,
   output logic              use_rt,
   output logic [DATA_W-1:0] imm1,
   output logic [DATA_W-1:0] imm2,
   output logic              we,
   output logic [REG_AW-1:0] waddr,
   output mov_e              mov,
   output logic              invalid
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sh;
   logic [15:0] imm;

   assign op  = inst[31:26];
   assign rs  = inst[25:21];
   assign rt  = inst[20:16];
   assign rd  = inst[15:11];
   assign sh  = inst[10:6];
   assign fn  = inst[5:0];
   assign imm = inst[15:0];

   always_comb begin
      aluop   = ALU_NOP;
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      imm1    = '0;
      imm2    = '0;
      we      = 1'b0;
      waddr   = REG_AW'(NOPRegAddr);
      mov     = MOV_NONE;
      invalid = 1'b1;
      case (op)
         EXE_ORI, EXE_ANDI, EXE_XORI: begin
            aluop   = (op == EXE_ORI)  ? ALU_OR :
                      (op == EXE_ANDI) ? ALU_AND : ALU_XOR;
            use_rs  = 1'b1;
            imm2    = DATA_W'(imm);
            we      = 1'b1;
            waddr   = REG_AW'(rt);
            invalid = 1'b0;
         end
         EXE_LUI: begin
            aluop   = ALU_OR;
            imm2    = DATA_W'({imm, 16'h0000});
            we      = 1'b1;
            waddr   = REG_AW'(rt);
            invalid = 1'b0;
         end
         EXE_SPECIAL: begin
            // funct codes of the fixed shifts are only legal with rs=0
            if (fn == EXE_SLL || fn == EXE_SRL || fn == EXE_SRA) begin
               if (rs == 5'd0) begin
                  aluop   = (fn == EXE_SLL) ? ALU_SLL :
                            (fn == EXE_SRL) ? ALU_SRL : ALU_SRA;
                  use_rt  = 1'b1;
                  imm1    = DATA_W'(sh);
                  we      = 1'b1;
                  waddr   = REG_AW'(rd);
                  invalid = 1'b0;
               end
            end else if (sh == 5'd0) begin
               use_rs  = 1'b1;
               use_rt  = 1'b1;
               we      = 1'b1;
               waddr   = REG_AW'(rd);
               invalid = 1'b0;
               case (fn)
                  EXE_AND:  aluop = ALU_AND;
                  EXE_OR:   aluop = ALU_OR;
                  EXE_XOR:  aluop = ALU_XOR;
                  EXE_NOR:  aluop = ALU_NOR;
                  EXE_SLLV: aluop = ALU_SLL;
                  EXE_SRLV: aluop = ALU_SRL;
                  EXE_SRAV: aluop = ALU_SRA;
                  EXE_MOVZ: begin
                     aluop = ALU_MOVZ;
                     mov   = MOV_Z;
                  end
                  EXE_MOVN: begin
                     aluop = ALU_MOVN;
                     mov   = MOV_N;
                  end
                  EXE_MFHI, EXE_MFLO: begin
                     aluop  = (fn == EXE_MFHI) ? ALU_MFHI : ALU_MFLO;
                     use_rs = 1'b0;
                     use_rt = 1'b0;
                  end
                  EXE_MTHI, EXE_MTLO: begin
                     aluop  = (fn == EXE_MTHI) ? ALU_MTHI : ALU_MTLO;
                     use_rt = 1'b0;
                     we     = 1'b0;
                  end
                  default: begin
                     use_rs  = 1'b0;
                     use_rt  = 1'b0;
                     we      = 1'b0;
                     waddr   = REG_AW'(NOPRegAddr);
                     invalid = 1'b1;
                  end
               endcase
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage with operand forwarding, load-use bubble insertion, valid/ready
// handshakes on both sides and the ID/EX pipeline register.
module id_stage_fwd
   import id_stage_fwd_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_inst,
   input  logic [31:0]               in_pc,
   output logic [REG_AW-1:0]         rd_addr1,
   output logic [REG_AW-1:0]         rd_addr2,
   input  logic [DATA_W-1:0]         rd_data1,
   input  logic [DATA_W-1:0]         rd_data2,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [AluOpLength-1:0]    out_aluop,
   output logic [DATA_W-1:0]         out_op1,
   output logic [DATA_W-1:0]         out_op2,
   output logic                      out_we,
   output logic [REG_AW-1:0]         out_waddr,
   output logic [31:0]               out_pc,
   output logic                      out_invalid,
   output logic [CNT_W-1:0]          stall_cnt
);

   alu_op_e           dec_aluop;
   logic              dec_use_rs;
   logic              dec_use_rt;
   logic [DATA_W-1:0] dec_imm1;
   logic [DATA_W-1:0] dec_imm2;
   logic              dec_we;
   logic [REG_AW-1:0] dec_waddr;
   mov_e              dec_mov;
   logic              dec_invalid;

   id_stage_fwd_decode #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_decode (
      .inst    (in_inst),
      .aluop   (dec_aluop),
      .use_rs  (dec_use_rs),
      .use_rt  (dec_use_rt),
      .imm1    (dec_imm1),
      .imm2    (dec_imm2),
      .we      (dec_we),
      .waddr   (dec_waddr),
      .mov     (dec_mov),
      .invalid (dec_invalid)
   );

   assign rd_addr1 = REG_AW'(in_inst[25:21]);
   assign rd_addr2 = REG_AW'(in_inst[20:16]);

   // Result is {pending, data}; the youngest matching source wins.
   function automatic logic [DATA_W:0] resolve(
      input logic [REG_AW-1:0]         addr,
      input logic [DATA_W-1:0]         rf_data,
      input logic [NUM_FWD-1:0]        src_we,
      input logic [NUM_FWD-1:0]        src_pend,
      input logic [NUM_FWD*REG_AW-1:0] src_addr,
      input logic [NUM_FWD*DATA_W-1:0] src_data
   );
      logic [DATA_W:0] res;
      res = {1'b0, rf_data};
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (src_we[i] && src_addr[i*REG_AW +: REG_AW] == addr)
            res = {src_pend[i], src_data[i*DATA_W +: DATA_W]};
      end
      if (addr == '0)
         res = '0;
      return res;
   endfunction

   logic [DATA_W:0]   rs_res;
   logic [DATA_W:0]   rt_res;
   logic [DATA_W-1:0] op1_val;
   logic [DATA_W-1:0] op2_val;
   logic              res_we;
   logic              hazard;
   logic              advance;

   assign rs_res  = resolve(rd_addr1, rd_data1, fwd_we, fwd_pending, fwd_addr, fwd_data);
   assign rt_res  = resolve(rd_addr2, rd_data2, fwd_we, fwd_pending, fwd_addr, fwd_data);
   assign op1_val = dec_use_rs ? rs_res[DATA_W-1:0] : dec_imm1;
   assign op2_val = dec_use_rt ? rt_res[DATA_W-1:0] : dec_imm2;
   assign hazard  = in_valid && ((dec_use_rs && rs_res[DATA_W]) ||
                                 (dec_use_rt && rt_res[DATA_W]));

   always_comb begin
      case (dec_mov)
         MOV_N:   res_we = (rt_res[DATA_W-1:0] != '0);
         MOV_Z:   res_we = (rt_res[DATA_W-1:0] == '0);
         default: res_we = dec_we;
      endcase
   end

   logic              valid_q,   valid_d;
   alu_op_e           aluop_q,   aluop_d;
   logic [DATA_W-1:0] op1_q,     op1_d;
   logic [DATA_W-1:0] op2_q,     op2_d;
   logic              we_q,      we_d;
   logic [REG_AW-1:0] waddr_q,   waddr_d;
   logic [31:0]       pc_q,      pc_d;
   logic              invalid_q, invalid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign advance  = !valid_q || out_ready;
   assign in_ready = rst && ((advance && !hazard) || flush);

   always_comb begin
      valid_d     = valid_q;
      aluop_d     = aluop_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      we_d        = we_q;
      waddr_d     = waddr_q;
      pc_d        = pc_q;
      invalid_d   = invalid_q;
      stall_cnt_d = stall_cnt_q;

      if (hazard && !flush && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      // a flush overrides backpressure, so it also loads when EX is stalled
      if (advance || flush) begin
         if (flush || hazard) begin
            valid_d   = 1'b0;
            aluop_d   = ALU_NOP;
            we_d      = 1'b0;
            invalid_d = 1'b0;
         end else begin
            valid_d   = in_valid;
            aluop_d   = dec_aluop;
            op1_d     = op1_val;
            op2_d     = op2_val;
            we_d      = res_we;
            waddr_d   = dec_waddr;
            pc_d      = in_pc;
            invalid_d = dec_invalid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         aluop_q     <= ALU_NOP;
         op1_q       <= '0;
         op2_q       <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         pc_q        <= '0;
         invalid_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         aluop_q     <= aluop_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         pc_q        <= pc_d;
         invalid_q   <= invalid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_aluop   = aluop_q;
   assign out_op1     = op1_q;
   assign out_op2     = op2_q;
   assign out_we      = we_q;
   assign out_waddr   = waddr_q;
   assign out_pc      = pc_q;
   assign out_invalid = invalid_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed and random stimulus for id_stage_fwd, checked against an
// instruction-level reference model of decode, forwarding and the handshake.
module tb_id_stage_fwd;
   import id_stage_fwd_pkg::*;

   localparam int NF = 2;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic [NF-1:0]    fwd_we;
   logic [NF-1:0]    fwd_pending;
   logic [NF*5-1:0]  fwd_addr;
   logic [NF*32-1:0] fwd_data;
   logic        out_valid;
   logic        out_ready;
   logic [AluOpLength-1:0] out_aluop;
   logic [31:0] out_op1;
   logic [31:0] out_op2;
   logic        out_we;
   logic [4:0]  out_waddr;
   logic [31:0] out_pc;
   logic        out_invalid;
   logic [15:0] stall_cnt;

   logic        f_we   [NF];
   logic        f_pend [NF];
   logic [4:0]  f_addr [NF];
   logic [31:0] f_data [NF];

   assign fwd_we      = {f_we[1], f_we[0]};
   assign fwd_pending = {f_pend[1], f_pend[0]};
   assign fwd_addr    = {f_addr[1], f_addr[0]};
   assign fwd_data    = {f_data[1], f_data[0]};

   id_stage_fwd dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .fwd_we(fwd_we), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
      .out_op1(out_op1), .out_op2(out_op2), .out_we(out_we), .out_waddr(out_waddr),
      .out_pc(out_pc), .out_invalid(out_invalid), .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   typedef struct {
      logic [7:0]  aluop;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        we;
      logic [4:0]  waddr;
      logic        inv;
      logic        haz;
   } exp_t;

   // Register lookup as seen by an instruction: {waiting, value}.
   function automatic logic [32:0] lookup(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 33'd0;
      for (int i = 0; i < NF; i++)
         if (f_we[i] && f_addr[i] == a) return {f_pend[i], f_data[i]};
      return {1'b0, rf};
   endfunction

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic [32:0] a, b;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, sh;
      op = w[31:26]; fn = w[5:0];
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6];
      a = lookup(rs, r1);
      b = lookup(rt, r2);
      e = '{aluop: ALU_NOP, op1: 0, op2: 0, we: 0, waddr: 0, inv: 1, haz: 0};
      if (op == 6'h0d || op == 6'h0c || op == 6'h0e) begin
         e.aluop = (op == 6'h0d) ? ALU_OR : (op == 6'h0c) ? ALU_AND : ALU_XOR;
         e.op1 = a[31:0]; e.op2 = {16'h0, w[15:0]}; e.haz = a[32];
         e.we = 1; e.waddr = rt; e.inv = 0;
      end else if (op == 6'h0f) begin
         e.aluop = ALU_OR; e.op2 = {w[15:0], 16'h0}; e.we = 1; e.waddr = rt; e.inv = 0;
      end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
         if (rs == 0) begin
            e.aluop = (fn == 6'h00) ? ALU_SLL : (fn == 6'h02) ? ALU_SRL : ALU_SRA;
            e.op1 = {27'h0, sh}; e.op2 = b[31:0]; e.haz = b[32];
            e.we = 1; e.waddr = rd; e.inv = 0;
         end
      end else if (op == 6'h00 && sh == 0) begin
         e.inv = 0; e.waddr = rd; e.we = 1;
         e.op1 = a[31:0]; e.op2 = b[31:0]; e.haz = a[32] | b[32];
         case (fn)
            6'h24: e.aluop = ALU_AND;
            6'h25: e.aluop = ALU_OR;
            6'h26: e.aluop = ALU_XOR;
            6'h27: e.aluop = ALU_NOR;
            6'h04: e.aluop = ALU_SLL;
            6'h06: e.aluop = ALU_SRL;
            6'h07: e.aluop = ALU_SRA;
            6'h0a: begin e.aluop = ALU_MOVZ; e.we = (b[31:0] == 0); end
            6'h0b: begin e.aluop = ALU_MOVN; e.we = (b[31:0] != 0); end
            6'h10, 6'h12: begin
               e.aluop = (fn == 6'h10) ? ALU_MFHI : ALU_MFLO;
               e.op1 = 0; e.op2 = 0; e.haz = 0;
            end
            6'h11, 6'h13: begin
               e.aluop = (fn == 6'h11) ? ALU_MTHI : ALU_MTLO;
               e.op2 = 0; e.haz = a[32]; e.we = 0;
            end
            default: e = '{aluop: ALU_NOP, op1: 0, op2: 0, we: 0, waddr: 0, inv: 1, haz: 0};
         endcase
      end
      return e;
   endfunction

   // Expected ID/EX content; m_known is cleared when the fields are don't-care.
   logic        m_valid, m_known;
   exp_t        m_f;
   logic [31:0] m_pc;
   logic [15:0] m_cnt;

   task automatic cycle();
      exp_t e;
      logic adv, hz, rdy;
      e   = model(in_inst, rd_data1, rd_data2);
      adv = !m_valid || out_ready;
      hz  = in_valid && e.haz;
      rdy = rst && ((adv && !hz) || flush);
      #1;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("rd_addr1", 32'(rd_addr1), 32'(in_inst[25:21]));
      chk("rd_addr2", 32'(rd_addr2), 32'(in_inst[20:16]));
      @(posedge clk);
      if (!rst) begin
         m_valid = 0; m_known = 1; m_pc = 0; m_cnt = 0;
         m_f = '{aluop: ALU_NOP, op1: 0, op2: 0, we: 0, waddr: 0, inv: 0, haz: 0};
      end else begin
         if (hz && !flush && m_cnt != 16'hffff) m_cnt = m_cnt + 1;
         if (flush || (adv && hz)) begin
            m_valid = 0; m_known = 0;
         end else if (adv) begin
            m_valid = in_valid; m_known = in_valid; m_f = e; m_pc = in_pc;
         end
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (m_known) begin
         chk("out_aluop",   32'(out_aluop),   32'(m_f.aluop));
         chk("out_op1",     out_op1,          m_f.op1);
         chk("out_op2",     out_op2,          m_f.op2);
         chk("out_we",      32'(out_we),      32'(m_f.we));
         chk("out_waddr",   32'(out_waddr),   32'(m_f.waddr));
         chk("out_invalid", 32'(out_invalid), 32'(m_f.inv));
         chk("out_pc",      out_pc,           m_pc);
      end
   endtask

   task automatic clear_fwd();
      for (int i = 0; i < NF; i++) begin
         f_we[i] = 0; f_pend[i] = 0; f_addr[i] = 0; f_data[i] = 0;
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] tbl [13];
      logic [4:0] rs, rt, rd, sh;
      logic [31:0] w;
      tbl = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07,
              6'h0a, 6'h0b, 6'h10, 6'h11, 6'h12, 6'h13};
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      sh = 5'($urandom_range(1, 31));
      case ($urandom_range(0, 9))
         0: w = {6'h0d, rs, rt, 16'($urandom)};
         1: w = {6'h0c, rs, rt, 16'($urandom)};
         2: w = {6'h0e, rs, rt, 16'($urandom)};
         3: w = {6'h0f, rs, rt, 16'($urandom)};
         4: w = {6'h00, 5'd0, rt, rd, sh, ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h03};
         5, 6, 7: w = {6'h00, rs, rt, rd, 5'd0, tbl[$urandom_range(0, 12)]};
         8: w = $urandom;
         default: w = {6'h00, rs, rt, rd, sh, 6'h25};
      endcase
      return w;
   endfunction

   initial begin
      rst = 0; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0;
      rd_data1 = 0; rd_data2 = 0; out_ready = 1;
      m_valid = 0; m_known = 0; m_pc = 0; m_cnt = 0;
      m_f = '{aluop: ALU_NOP, op1: 0, op2: 0, we: 0, waddr: 0, inv: 0, haz: 0};
      clear_fwd();
      cycle();
      rst = 1;

      // stream of ORI ops, then a one-cycle reset in the middle
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_inst = 32'h3401_0000 | 32'(k + 7); in_pc = 32'h100 + 32'(4 * k);
         cycle();
      end
      rst = 0;
      cycle();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      rst = 1;

      // ORI $1,$0,0x1100
      in_inst = 32'h3401_1100; in_pc = 32'h200;
      cycle();
      chk("ori_valid", 32'(out_valid), 32'd1);
      chk("ori_aluop", 32'(out_aluop), 32'(ALU_OR));
      chk("ori_op1", out_op1, 32'h0);
      chk("ori_op2", out_op2, 32'h0000_1100);
      chk("ori_waddr", 32'(out_waddr), 32'd1);

      // OR $3,$1,$2 with both sources matching $1: EX must win
      in_inst = 32'h0022_1825; in_pc = 32'h204; rd_data2 = 32'h1234_5678;
      f_we[0] = 1; f_addr[0] = 5'd1; f_data[0] = 32'hA5A5_0000;
      f_we[1] = 1; f_addr[1] = 5'd1; f_data[1] = 32'h0000_0001;
      cycle();
      chk("fwd_op1", out_op1, 32'hA5A5_0000);
      chk("fwd_op2", out_op2, 32'h1234_5678);

      // SLLV $5,$6,$4 with a load in flight on $4 for two cycles
      clear_fwd();
      in_inst = 32'h0086_2804; in_pc = 32'h208; rd_data2 = 32'h0000_0003;
      f_we[0] = 1; f_addr[0] = 5'd4; f_pend[0] = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("lu_in_ready", 32'(in_ready), 32'd0);
         cycle();
         chk("lu_bubble", 32'(out_valid), 32'd0);
      end
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd2);
      f_pend[0] = 0; f_data[0] = 32'hDEAD_BEEF;
      cycle();
      chk("lu_issue", 32'(out_valid), 32'd1);
      chk("lu_op1", out_op1, 32'hDEAD_BEEF);

      // MOVZ $7,$1,$2 with rt resolving to 0 and then to 5
      clear_fwd();
      in_inst = 32'h0022_380A; rd_data1 = 32'h55; rd_data2 = 32'h0;
      cycle();
      chk("movz_we1", 32'(out_we), 32'd1);
      rd_data2 = 32'h5;
      cycle();
      chk("movz_we0", 32'(out_we), 32'd0);

      // backpressure holds the stage; a flush then drops the input word
      in_inst = 32'h0022_1827; in_pc = 32'h300; rd_data1 = 32'hF0F0; rd_data2 = 32'h0F00;
      cycle();
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_inst = 32'h3403_0000 | 32'(k); in_pc = 32'h400 + 32'(k);
         cycle();
         chk("bp_op1", out_op1, 32'hF0F0);
      end
      flush = 1;
      cycle();
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 0; out_ready = 1;

      // reserved instruction
      in_inst = 32'hFC00_0000;
      cycle();
      chk("inv_flag", 32'(out_invalid), 32'd1);
      chk("inv_aluop", 32'(out_aluop), 32'(ALU_NOP));
      chk("inv_we", 32'(out_we), 32'd0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         rd_data1  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         rd_data2  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         for (int i = 0; i < NF; i++) begin
            f_we[i]   = ($urandom_range(0, 1) == 1);
            f_pend[i] = ($urandom_range(0, 3) == 0);
            f_addr[i] = 5'($urandom_range(0, 7));
            f_data[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
